ncl_sync_bridge: RTL

Synchronous-side driver and receiver for the dual-rail NCL adder datapath. Accepts single-rail operands over a valid/ready handshake and encodes them as dual-rail DATA wavefronts. It detects completion of the adder's dual-rail result, then captures and decodes the result for the synchronous consumer. It finally sequences the NULL wavefront that resets the NCL stage for the next operation. It sits between the clocked control logic and the `somador` NCL datapath, and is the only clocked agent on that dual-rail interface.

---
 rtl/ncl_pkg.sv | 35 +++
 rtl/ncl_completion_detect.sv | 50 +++++
 rtl/ncl_sync_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// Shared types and dual-rail helpers for the synchronous NCL bridge.
// Rail order per bit is {true, false}; DR_MAXW bounds the helper functions' width.
package ncl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    NULL_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_F    = 2'b01;

  localparam int DR_MAXW = 64;

  function automatic logic [2*DR_MAXW-1:0] dr_encode(input logic [DR_MAXW-1:0] sr);
    logic [2*DR_MAXW-1:0] dr;
    dr = '0;
    for (int i = 0; i < DR_MAXW; i++) begin
      dr[2*i +: 2] = sr[i] ? DR_T : DR_F;
    end
    return dr;
  endfunction

  function automatic logic [DR_MAXW-1:0] dr_decode(input logic [2*DR_MAXW-1:0] dr);
    logic [DR_MAXW-1:0] sr;
    sr = '0;
    for (int i = 0; i < DR_MAXW; i++) begin
      sr[i] = dr[2*i+1];
    end
    return sr;
  endfunction

endpackage

// File: rtl/ncl_completion_detect.sv
// Two-flop synchronizer on every result rail plus wavefront detection on the second stage.
// Detection outputs are held low until both stages hold post-reset samples of the real rails.
module ncl_completion_detect
  import ncl_pkg::*;
#(
  parameter int NPAIRS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NPAIRS-1:0]   rails_i,
  output logic [2*NPAIRS-1:0]   rails_sync_o,
  output logic                  all_data_o,
  output logic                  all_null_o,
  output logic                  any_illegal_o
);

  logic [2*NPAIRS-1:0] sync1_q;
  logic [2*NPAIRS-1:0] sync2_q;
  logic [1:0]          prime_q;
  logic                data_v;
  logic                ill_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= rails_i;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  always_comb begin
    data_v = 1'b1;
    ill_v  = 1'b0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (sync2_q[2*i] == sync2_q[2*i+1]) data_v = 1'b0;
      if (sync2_q[2*i +: 2] == 2'b11)      ill_v  = 1'b1;
    end
  end

  // The reset value of the synchronizer would otherwise read as a false all_null.
  assign all_data_o    = prime_q[1] && data_v;
  assign all_null_o    = prime_q[1] && (sync2_q == '0);
  assign any_illegal_o = prime_q[1] && ill_v;
  assign rails_sync_o  = sync2_q;

endmodule

// File: rtl/ncl_sync_bridge.sv
// Clocked driver/receiver for the dual-rail NCL adder: encodes operands, waits for
// completion, captures the decoded result and sequences the NULL wavefront.
module ncl_sync_bridge
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_soma,
  output logic               out_ovf,
  output logic [2*WIDTH-1:0] ncl_a,
  output logic [2*WIDTH-1:0] ncl_b,
  output logic [1:0]         ncl_cin,
  input  logic [2*WIDTH-1:0] ncl_soma,
  input  logic [1:0]         ncl_ovf,
  output logic               err_timeout,
  output logic               err_illegal,
  output state_e             dbg_state
);

  localparam int NP = WIDTH + 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   ncl_a_q, ncl_a_d, ncl_b_q, ncl_b_d;
  logic [1:0]           ncl_cin_q, ncl_cin_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_soma_q, out_soma_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_illegal_q, err_illegal_d;

  logic [2*NP-1:0]      rails_sync;
  logic                 all_data, all_null, any_illegal;
  logic                 hs, complete, data_to, null_to, cnt_hit;
  logic [DR_MAXW-1:0]   a_ext, b_ext, soma_dec;
  logic [2*DR_MAXW-1:0] a_enc, b_enc, soma_ext;
  logic                 unused_bits;

  ncl_completion_detect #(.NPAIRS(NP)) u_cd (
    .clk           (clk),
    .rst_n         (rst_n),
    .rails_i       ({ncl_ovf, ncl_soma}),
    .rails_sync_o  (rails_sync),
    .all_data_o    (all_data),
    .all_null_o    (all_null),
    .any_illegal_o (any_illegal)
  );

  always_comb begin
    a_ext    = '0;
    b_ext    = '0;
    soma_ext = '0;
    a_ext[WIDTH-1:0]      = in_a;
    b_ext[WIDTH-1:0]      = in_b;
    soma_ext[2*WIDTH-1:0] = rails_sync[2*WIDTH-1:0];
  end

  assign a_enc       = dr_encode(a_ext);
  assign b_enc       = dr_encode(b_ext);
  assign soma_dec    = dr_decode(soma_ext);
  assign unused_bits = ^{a_enc[2*DR_MAXW-1:2*WIDTH], b_enc[2*DR_MAXW-1:2*WIDTH],
                         soma_dec[DR_MAXW-1:WIDTH], rails_sync[2*WIDTH]};

  // Handshake: a transfer happens on any rising edge where valid and ready are both high.
  assign hs       = (state_q == IDLE) && in_valid && in_ready;
  assign cnt_hit  = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign complete = (state_q == DATA) && all_data;
  assign data_to  = (state_q == DATA) && !all_data && cnt_hit;
  assign null_to  = (state_q == NULL_WAIT) && !all_null && cnt_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hs) state_d = DATA;
      DATA:      if (complete || data_to) state_d = NULL_WAIT;
      NULL_WAIT: if (all_null) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && all_null && !out_valid_q;
    dbg_state = state_q;
  end

  always_comb begin
    ncl_a_d       = ncl_a_q;
    ncl_b_d       = ncl_b_q;
    ncl_cin_d     = ncl_cin_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_soma_d    = out_soma_q;
    out_ovf_d     = out_ovf_q;
    err_timeout_d = err_timeout_q | data_to | null_to;
    err_illegal_d = err_illegal_q | ((state_q != IDLE) && any_illegal);

    if (hs) begin
      ncl_a_d   = a_enc[2*WIDTH-1:0];
      ncl_b_d   = b_enc[2*WIDTH-1:0];
      ncl_cin_d = in_cin ? DR_T : DR_F;
    end else if (complete || data_to) begin
      ncl_a_d   = {WIDTH{DR_NULL}};
      ncl_b_d   = {WIDTH{DR_NULL}};
      ncl_cin_d = DR_NULL;
    end

    // Saturates at TIMEOUT_CYC so a stuck NULL_WAIT flags once and then just waits.
    if (state_d != state_q && state_d != IDLE) cnt_d = '0;
    else if (state_q != IDLE && cnt_q != CW'(TIMEOUT_CYC)) cnt_d = cnt_q + CW'(1);

    if (complete) begin
      out_valid_d = 1'b1;
      out_soma_d  = soma_dec[WIDTH-1:0];
      out_ovf_d   = rails_sync[2*WIDTH+1];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncl_a_q       <= {WIDTH{DR_NULL}};
      ncl_b_q       <= {WIDTH{DR_NULL}};
      ncl_cin_q     <= DR_NULL;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_soma_q    <= '0;
      out_ovf_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      ncl_a_q       <= ncl_a_d;
      ncl_b_q       <= ncl_b_d;
      ncl_cin_q     <= ncl_cin_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_soma_q    <= out_soma_d;
      out_ovf_q     <= out_ovf_d;
      err_timeout_q <= err_timeout_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign ncl_a       = ncl_a_q;
  assign ncl_b       = ncl_b_q;
  assign ncl_cin     = ncl_cin_q;
  assign out_valid   = out_valid_q;
  assign out_soma    = out_soma_q;
  assign out_ovf     = out_ovf_q;
  assign err_timeout = err_timeout_q;
  assign err_illegal = err_illegal_q;

endmodule
